rvm_trap_ctrl: RTL and testbench



---
 rtl/rvm_trap_ctrl_pkg.sv | 28 ++
 rtl/rvm_trap_prio.sv | 19 +
 rtl/rvm_trap_ctrl.sv | 116 +++++++++++
 tb/tb_rvm_trap_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rvm_trap_ctrl_pkg.sv
// rvm_trap_ctrl_pkg: cause codes, sequencer states and interrupt priority for the trap controller
package rvm_trap_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ENTRY     = 2'd1,
      ST_MRET_EXIT = 2'd2,
      ST_REDIRECT  = 2'd3
   } trap_st_e;
   localparam logic [4:0] CAUSE_IADDR_MISALIGN = 5'd0;
   localparam logic [4:0] CAUSE_IADDR_FAULT    = 5'd1;
   localparam logic [4:0] CAUSE_ILLEGAL_INSTR  = 5'd2;
   localparam logic [4:0] CAUSE_BREAKPOINT     = 5'd3;
   localparam logic [4:0] CAUSE_LADDR_MISALIGN = 5'd4;
   localparam logic [4:0] CAUSE_LADDR_FAULT    = 5'd5;
   localparam logic [4:0] CAUSE_SADDR_MISALIGN = 5'd6;
   localparam logic [4:0] CAUSE_SADDR_FAULT    = 5'd7;
   localparam logic [4:0] CAUSE_MSI            = 5'd3;
   localparam logic [4:0] CAUSE_MTI            = 5'd7;
   localparam logic [4:0] CAUSE_MEI            = 5'd11;
   // bit positions inside irq_pending = {mei,mti,msi}; priority is MEI, MSI, MTI
   localparam int IRQ_MSI = 0;
   localparam int IRQ_MTI = 1;
   localparam int IRQ_MEI = 2;
   function automatic logic badaddr_cause(input logic [4:0] c);
      return c inside {CAUSE_IADDR_MISALIGN, CAUSE_IADDR_FAULT, CAUSE_LADDR_MISALIGN,
                       CAUSE_LADDR_FAULT, CAUSE_SADDR_MISALIGN, CAUSE_SADDR_FAULT};
   endfunction
endpackage

// File: rtl/rvm_trap_prio.sv
// rvm_trap_prio: picks one trap; lowest exception bit first, then MEI > MSI > MTI
module rvm_trap_prio
   import rvm_trap_ctrl_pkg::*;
(
   input  logic [7:0] exc_vec,
   input  logic [2:0] irq_pending,
   input  logic       irq_en,
   output logic       take,
   output logic       is_irq,
   output logic [4:0] cause
);
   always_comb begin
      cause = '0;
      for (int i = 7; i >= 0; i--) if (exc_vec[i]) cause = 5'(i);
      is_irq = ~|exc_vec & irq_en & |irq_pending;
      take = |exc_vec | is_irq;
      if (is_irq) cause = irq_pending[IRQ_MEI] ? CAUSE_MEI : irq_pending[IRQ_MSI] ? CAUSE_MSI : CAUSE_MTI;
   end
endmodule

// File: rtl/rvm_trap_ctrl.sv
// rvm_trap_ctrl: sequences trap entry and MRET exit, updates mstatus and redirects the PCU
module rvm_trap_ctrl
   import rvm_trap_ctrl_pkg::*;
#(
   parameter bit   VECTORED_EN      = 1'b0,
   parameter logic MSTATUS_MPIE_RST = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_stall,
   input  logic        instr_boundary,
   input  logic [31:0] pc,
   input  logic [7:0]  exc_vec,
   input  logic [31:0] exc_badaddr,
   input  logic [2:0]  irq_pending,
   input  logic        op_mret,
   input  logic [29:0] mtvec,
   input  logic [31:0] mepc_in,
   input  logic        mstatus_we,
   input  logic [1:0]  mstatus_wdata,
   output logic        csr_trap_we,
   output logic [31:0] csr_mepc,
   output logic [31:0] csr_mcause,
   output logic        csr_mbadaddr_we,
   output logic [31:0] csr_mbadaddr,
   output logic        mstatus_mie,
   output logic        mstatus_mpie,
   output logic        redirect_valid,
   output logic [31:0] redirect_target,
   input  logic        redirect_ready,
   output logic        busy
);
   trap_st_e    state_q, state_d;
   logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mbad_q, mbad_d, target_q, target_d;
   logic        mie_q, mie_d, mpie_q, mpie_d;
   logic        take, is_irq, accept, trap, mret;
   logic [4:0]  cause;
   logic [31:0] base;
   rvm_trap_prio u_prio (
      .exc_vec     (exc_vec),
      .irq_pending (irq_pending),
      .irq_en      (instr_boundary & mie_q),
      .take        (take),
      .is_irq      (is_irq),
      .cause       (cause)
   );
   assign accept = (state_q == ST_IDLE) && !core_stall;
   assign trap   = accept && take;
   assign mret   = accept && !take && op_mret && instr_boundary;
   assign base   = {mtvec, 2'b00};
   always_comb begin
      state_d  = state_q;
      mepc_d   = mepc_q;
      mcause_d = mcause_q;
      mbad_d   = mbad_q;
      target_d = target_q;
      mie_d    = mie_q;
      mpie_d   = mpie_q;
      case (state_q)
         ST_IDLE:
            if (trap) begin
               state_d  = ST_ENTRY;
               mepc_d   = pc;
               mcause_d = {is_irq, 26'b0, cause};
               mbad_d   = exc_badaddr;
               target_d = (VECTORED_EN && is_irq) ? base + {25'b0, cause, 2'b00} : base;
            end else if (mret) begin
               state_d  = ST_MRET_EXIT;
               target_d = mepc_in & ~32'h3;
            end else if (mstatus_we) begin
               mpie_d = mstatus_wdata[1];
               mie_d  = mstatus_wdata[0];
            end
         ST_ENTRY: begin
            mpie_d  = mie_q;
            mie_d   = 1'b0;
            state_d = ST_REDIRECT;
         end
         ST_MRET_EXIT: begin
            mie_d   = mpie_q;
            mpie_d  = 1'b1;
            state_d = ST_REDIRECT;
         end
         default: if (redirect_ready) state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         mepc_q   <= '0;
         mcause_q <= '0;
         mbad_q   <= '0;
         target_q <= '0;
         mie_q    <= 1'b0;
         mpie_q   <= MSTATUS_MPIE_RST;
      end else begin
         state_q  <= state_d;
         mepc_q   <= mepc_d;
         mcause_q <= mcause_d;
         mbad_q   <= mbad_d;
         target_q <= target_d;
         mie_q    <= mie_d;
         mpie_q   <= mpie_d;
      end
   end
   assign csr_trap_we     = state_q == ST_ENTRY;
   assign csr_mbadaddr_we = csr_trap_we && !mcause_q[31] && badaddr_cause(mcause_q[4:0]);
   assign csr_mepc        = mepc_q;
   assign csr_mcause      = mcause_q;
   assign csr_mbadaddr    = mbad_q;
   assign mstatus_mie     = mie_q;
   assign mstatus_mpie    = mpie_q;
   assign redirect_valid  = state_q == ST_REDIRECT;
   assign redirect_target = target_q;
   assign busy            = state_q != ST_IDLE;
endmodule

// File: tb/tb_rvm_trap_ctrl.sv
// tb_rvm_trap_ctrl: table vectors plus random transactions against a rule-level trap model
module tb_rvm_trap_ctrl;
   logic        clk = 1'b0;
   logic        reset, core_stall, instr_boundary, op_mret, mstatus_we, redirect_ready;
   logic [31:0] pc, exc_badaddr, mepc_in;
   logic [7:0]  exc_vec;
   logic [2:0]  irq_pending;
   logic [29:0] mtvec;
   logic [1:0]  mstatus_wdata;
   logic        csr_trap_we, csr_mbadaddr_we, mstatus_mie, mstatus_mpie, redirect_valid, busy;
   logic [31:0] csr_mepc, csr_mcause, csr_mbadaddr, redirect_target;

   always #5 clk = ~clk;

   rvm_trap_ctrl #(.VECTORED_EN(1'b1), .MSTATUS_MPIE_RST(1'b0)) dut (
      .clk(clk), .reset(reset), .core_stall(core_stall), .instr_boundary(instr_boundary),
      .pc(pc), .exc_vec(exc_vec), .exc_badaddr(exc_badaddr), .irq_pending(irq_pending),
      .op_mret(op_mret), .mtvec(mtvec), .mepc_in(mepc_in), .mstatus_we(mstatus_we),
      .mstatus_wdata(mstatus_wdata), .csr_trap_we(csr_trap_we), .csr_mepc(csr_mepc),
      .csr_mcause(csr_mcause), .csr_mbadaddr_we(csr_mbadaddr_we), .csr_mbadaddr(csr_mbadaddr),
      .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .redirect_ready(redirect_ready), .busy(busy)
   );

   typedef enum int {K_NONE, K_TRAP, K_MRET} kind_e;
   typedef struct {
      logic [7:0]  exc;
      logic [2:0]  irq;
      logic        ib, mret, stall;
      logic [31:0] pc, bad;
      logic [29:0] mtvec;
      logic [31:0] mepc;
      logic        we;
      logic [1:0]  wdata, pre;
      kind_e       kind;
      logic [31:0] mcause, target;
      logic        bad_we;
      logic [1:0]  st;
      int          hold;
   } vec_t;

   vec_t tbl[15];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in;
      exc_vec = '0;
      irq_pending = '0;
      instr_boundary = 1'b0;
      op_mret = 1'b0;
      core_stall = 1'b0;
      mstatus_we = 1'b0;
   endtask

   // trap rules stated directly: lowest exception bit, then MEI/MSI/MTI, then MRET
   function automatic vec_t model(input vec_t v);
      int pr[3]  = '{11, 3, 7};
      int bpos[3] = '{2, 0, 1};
      int c;
      v.kind = K_NONE;
      v.st = v.we ? v.wdata : v.pre;
      v.mcause = 0;
      v.target = 0;
      v.bad_we = 1'b0;
      if (!v.stall) begin
         if (v.exc != 0) begin
            c = -1;
            for (int i = 0; i < 8; i++) if (c < 0 && v.exc[i]) c = i;
            v.kind = K_TRAP;
            v.mcause = 32'(c);
            v.bad_we = (c == 0 || c == 1 || (c >= 4 && c <= 7));
            v.target = {v.mtvec, 2'b00};
         end else if (v.ib && v.pre[0] && v.irq != 0) begin
            c = -1;
            for (int i = 0; i < 3; i++) if (c < 0 && v.irq[bpos[i]]) c = pr[i];
            v.kind = K_TRAP;
            v.mcause = 32'h8000_0000 + 32'(c);
            v.target = {v.mtvec, 2'b00} + 32'(4 * c);
         end else if (v.mret && v.ib) begin
            v.kind = K_MRET;
            v.target = v.mepc & 32'hFFFF_FFFC;
         end
         if (v.kind == K_TRAP) v.st = {v.pre[0], 1'b0};
         if (v.kind == K_MRET) v.st = {1'b1, v.pre[1]};
      end
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      idle_in();
      mstatus_we = 1'b1;
      mstatus_wdata = v.pre;
      cyc();
      mstatus_we = 1'b0;
      chk("preset_mstatus", {30'b0, mstatus_mpie, mstatus_mie}, {30'b0, v.pre});
      exc_vec = v.exc;
      irq_pending = v.irq;
      instr_boundary = v.ib;
      op_mret = v.mret;
      core_stall = v.stall;
      pc = v.pc;
      exc_badaddr = v.bad;
      mtvec = v.mtvec;
      mepc_in = v.mepc;
      mstatus_we = v.we;
      mstatus_wdata = v.wdata;
      redirect_ready = 1'b1;
      chk("idle_busy", busy, 0);
      cyc();
      idle_in();
      if (v.kind == K_NONE) begin
         chk("none_busy", busy, 0);
         chk("none_trap_we", csr_trap_we, 0);
         chk("none_mstatus", {30'b0, mstatus_mpie, mstatus_mie}, {30'b0, v.st});
      end else begin
         chk("seq_busy", busy, 1);
         chk("seq_trap_we", csr_trap_we, v.kind == K_TRAP);
         chk("seq_rv_early", redirect_valid, 0);
         if (v.kind == K_TRAP) begin
            chk("mepc", csr_mepc, v.pc);
            chk("mcause", csr_mcause, v.mcause);
            chk("mbadaddr_we", csr_mbadaddr_we, v.bad_we);
            if (v.bad_we) chk("mbadaddr", csr_mbadaddr, v.bad);
         end
         redirect_ready = 1'b0;
         cyc();
         chk("redir_valid", redirect_valid, 1);
         chk("redir_target", redirect_target, v.target);
         chk("redir_trap_we", csr_trap_we, 0);
         chk("redir_mstatus", {30'b0, mstatus_mpie, mstatus_mie}, {30'b0, v.st});
         for (int i = 0; i < v.hold; i++) begin
            cyc();
            chk("hold_valid", redirect_valid, 1);
            chk("hold_target", redirect_target, v.target);
            chk("hold_busy", busy, 1);
         end
         redirect_ready = 1'b1;
         cyc();
         redirect_ready = 1'b0;
         chk("exit_busy", busy, 0);
         chk("exit_valid", redirect_valid, 0);
      end
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_trap_we"}, csr_trap_we, 0);
      chk({nm, "_bad_we"}, csr_mbadaddr_we, 0);
      chk({nm, "_rv"}, redirect_valid, 0);
      chk({nm, "_target"}, redirect_target, 0);
      chk({nm, "_mepc"}, csr_mepc, 0);
      chk({nm, "_mcause"}, csr_mcause, 0);
      chk({nm, "_mbad"}, csr_mbadaddr, 0);
      chk({nm, "_mstatus"}, {30'b0, mstatus_mpie, mstatus_mie}, 0);
   endtask

   initial begin
      vec_t v;
      tbl[0]  = '{8'h04, 3'b000, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,       30'h70, 32'h0,   1'b0, 2'b00, 2'b01, K_TRAP, 32'h2,         32'h1C0,      1'b0, 2'b10, 0};
      tbl[1]  = '{8'h30, 3'b000, 1'b0, 1'b0, 1'b0, 32'h104, 32'h2003,    30'h70, 32'h0,   1'b0, 2'b00, 2'b01, K_TRAP, 32'h4,         32'h1C0,      1'b1, 2'b10, 1};
      tbl[2]  = '{8'h00, 3'b111, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0,       30'h70, 32'h0,   1'b0, 2'b00, 2'b01, K_TRAP, 32'h8000_000B, 32'h1EC,      1'b0, 2'b10, 0};
      tbl[3]  = '{8'h00, 3'b111, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0,       30'h70, 32'h0,   1'b0, 2'b00, 2'b10, K_NONE, 32'h0,         32'h0,        1'b0, 2'b10, 0};
      tbl[4]  = '{8'h00, 3'b000, 1'b1, 1'b1, 1'b0, 32'h208, 32'h0,       30'h70, 32'h404, 1'b0, 2'b00, 2'b10, K_MRET, 32'h0,         32'h404,      1'b0, 2'b11, 2};
      tbl[5]  = '{8'h04, 3'b000, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0,       30'h70, 32'h404, 1'b0, 2'b00, 2'b10, K_TRAP, 32'h2,         32'h1C0,      1'b0, 2'b00, 0};
      tbl[6]  = '{8'h01, 3'b000, 1'b0, 1'b0, 1'b0, 32'h304, 32'hDEADBEE0, 30'h70, 32'h0,  1'b0, 2'b00, 2'b00, K_TRAP, 32'h0,         32'h1C0,      1'b1, 2'b00, 5};
      tbl[7]  = '{8'h00, 3'b011, 1'b1, 1'b0, 1'b0, 32'h308, 32'h0,       30'h70, 32'h0,   1'b0, 2'b00, 2'b01, K_TRAP, 32'h8000_0003, 32'h1CC,      1'b0, 2'b10, 0};
      tbl[8]  = '{8'h00, 3'b010, 1'b1, 1'b0, 1'b0, 32'h30C, 32'h0,       30'h70, 32'h0,   1'b0, 2'b00, 2'b11, K_TRAP, 32'h8000_0007, 32'h1DC,      1'b0, 2'b10, 0};
      tbl[9]  = '{8'h01, 3'b000, 1'b0, 1'b0, 1'b1, 32'h310, 32'h0,       30'h70, 32'h0,   1'b1, 2'b11, 2'b00, K_NONE, 32'h0,         32'h0,        1'b0, 2'b11, 0};
      tbl[10] = '{8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 32'h314, 32'h0,       30'h70, 32'h0,   1'b1, 2'b10, 2'b01, K_NONE, 32'h0,         32'h0,        1'b0, 2'b10, 0};
      tbl[11] = '{8'h80, 3'b000, 1'b0, 1'b0, 1'b0, 32'h318, 32'h1234,    30'h3FFF_FFFF, 32'h0, 1'b0, 2'b00, 2'b01, K_TRAP, 32'h7,    32'hFFFF_FFFC, 1'b1, 2'b10, 0};
      tbl[12] = '{8'h00, 3'b100, 1'b1, 1'b0, 1'b0, 32'h31C, 32'h0,       30'h3FFF_FFFF, 32'h0, 1'b0, 2'b00, 2'b01, K_TRAP, 32'h8000_000B, 32'h28,   1'b0, 2'b10, 0};
      tbl[13] = '{8'h08, 3'b000, 1'b0, 1'b0, 1'b0, 32'h320, 32'h0,       30'h70, 32'h0,   1'b1, 2'b11, 2'b01, K_TRAP, 32'h3,         32'h1C0,      1'b0, 2'b10, 0};
      tbl[14] = '{8'h00, 3'b111, 1'b0, 1'b0, 1'b0, 32'h324, 32'h0,       30'h70, 32'h0,   1'b0, 2'b00, 2'b01, K_NONE, 32'h0,         32'h0,        1'b0, 2'b01, 0};

      reset = 1'b1;
      idle_in();
      redirect_ready = 1'b1;
      pc = '0;
      exc_badaddr = '0;
      mtvec = '0;
      mepc_in = '0;
      mstatus_wdata = '0;
      cyc();
      cyc();
      chk_reset_outputs("reset");
      reset = 1'b0;
      cyc();
      chk("ready_in_idle_busy", busy, 0);
      redirect_ready = 1'b0;

      foreach (tbl[i]) run_vec(tbl[i]);

      for (int n = 0; n < 150; n++) begin
         v.exc    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         v.irq    = 3'($urandom);
         v.ib     = 1'($urandom);
         v.mret   = 1'($urandom);
         v.stall  = ($urandom_range(0, 7) == 0);
         v.pc     = $urandom;
         v.bad    = $urandom;
         v.mtvec  = 30'($urandom);
         v.mepc   = $urandom;
         v.we     = ($urandom_range(0, 3) == 0);
         v.wdata  = 2'($urandom);
         v.pre    = 2'($urandom);
         v.hold   = $urandom_range(0, 3);
         run_vec(model(v));
      end

      idle_in();
      exc_vec = 8'h01;
      pc = 32'h500;
      mtvec = 30'h70;
      cyc();
      idle_in();
      chk("rst_entry_trap_we", csr_trap_we, 1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk_reset_outputs("rst_entry");

      exc_vec = 8'h02;
      cyc();
      idle_in();
      cyc();
      chk("rst_redir_valid", redirect_valid, 1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst_redir_drop", redirect_valid, 0);
      chk("rst_redir_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
